mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide execution unit in the EX stage of the 5-stage RISC-V pipeline.
- Consumes the decoder's activate_mul_module and 4-bit ALU control code for R-type funct7=0000001 instructions, registered through ID/EX.
- Produces a 32-bit result with destination register tag for the EX/MEM write-back path.
- Raises a stall request that the hazard unit uses to hold PC, IF/ID and ID/EX while an operation is in flight.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  ID/EX activate_mul_module, qualified by a valid instruction
op  input  4  ID/EX ALU control: 0000 MUL, 0001 MULH, 0100 DIV, 0110 REM
rs1_val  input  XLEN  forwarded operand A (multiplicand/dividend)
rs2_val  input  XLEN  forwarded operand B (multiplier/divisor)
rd_in  input  5  destination register
flush  input  1  synchronous abort (branch taken / pipeline flush)
stall_req  output  1  combinational hold request to the hazard unit
busy  output  1  registered, state != IDLE
result_valid  output  1  one-cycle result strobe
result  output  XLEN  operation result, held until the next accepted start
rd_out  output  5  destination tag of result

Behaviour:
- Clock is clk. Reset is asynchronous and active-high.
- Reset, asynchronous: state=IDLE, counter=0, busy=0, result_valid=0, result=0, rd_out=0. All internal accumulators are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at a rising edge: latch op, rd_in and operand magnitudes (signed interpretation for all four ops), record sign flags, counter=0.
  - Special cases go straight to DONE with the result computed in that edge:
    - DIV with rs2=0 → 0xFFFFFFFF.
    - REM with rs2=0 → rs1.
    - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
    - REM of the same operands → 0.
  - All other cases go to CALC.
  - Unsupported op code → DONE, result=0.
- CALC: one iteration per edge, 32 edges, counter increments 0..31. When counter=31, move to FIX.
  - MUL/MULH: radix-2 shift-add on magnitudes into a 64-bit product.
  - DIV/REM: restoring division on magnitudes, producing a 32-bit quotient and remainder.
- FIX: one edge, sign correction, then move to DONE.
  - MUL: low 32 bits of the signed product.
  - MULH: high 32 bits of the signed product.
  - DIV: quotient negated if the operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - The correct result is registered into result.
- DONE: result_valid=1 for exactly one cycle, then IDLE on the next edge.
- Latency, counted from the start-sampling edge as edge 0: result_valid is high in the cycle after edge 33 for normal ops, and in the cycle after edge 0 for special cases.
- stall_req = (state==CALC) | (state==FIX) | (state==IDLE & start & ~flush & ~special_case).
  - stall_req is low in DONE, so the pipeline advances in the same cycle result_valid is presented.
- busy = (state != IDLE), registered.
- start while state != IDLE is ignored. It cannot legally occur because stall_req holds ID/EX; the bench asserts this.
- flush=1 at an edge in any state except IDLE: go to IDLE, no result_valid. result and rd_out keep their previous values.
- flush and start together in IDLE: start is ignored.
- flush has priority over the CALC→FIX and FIX→DONE transitions.
- reset mid-operation: immediate return to reset values, no result_valid.
- Widths: the internal product is 2·XLEN. The division remainder register is XLEN+1 bits for the restoring subtract. Negation is two's complement modulo 2^XLEN.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (−3), rd=5 → stall_req high 33 cycles; result_valid once after edge 33; result=0xFFFFFFEB, rd_out=5.
- MULH rs1=0x80000000, rs2=0x80000000 → result=0x40000000. MULH rs1=0xFFFFFFFF, rs2=2 → result=0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → result=0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIV 100/7 → 14. REM 100/7 → 2.
- Special cases, all with result_valid one cycle after start and stall_req never asserted:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Start MUL 3×4 then assert flush at iteration 10 → busy low next edge, no result_valid, result unchanged. Then start MUL 3×4 → result=12.
- Start DIV, assert reset asynchronously mid-CALC → outputs zero immediately without a clock edge. After release, DIV 9/3 → 3.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply / restoring divide for the EX stage.
// Signed ops run on magnitudes for 32 edges, then one edge of sign correction.
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall_req,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   localparam logic [3:0] OP_MUL = 4'b0000, OP_MULH = 4'b0001, OP_DIV = 4'b0100, OP_REM = 4'b0110;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1), LAST = CNT_W'(XLEN-1);
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic              s1_q, s1_d, s2_q, s2_d, valid_q, valid_d, busy_q;
   logic [XLEN-1:0]   m_q, m_d, result_q, result_d;
   logic [2*XLEN-1:0] prod_q, prod_d, step, sprod;
   logic [4:0]        tag_q, tag_d, rd_q, rd_d;
   logic              is_div, is_rem, is_dr, supported, special;
   logic [XLEN-1:0]   abs1, abs2, special_res, quo, rem, fix_res;
   logic [XLEN:0]     add_w, rem_w, diff_w;
   assign is_div    = op == OP_DIV;
   assign is_rem    = op == OP_REM;
   assign is_dr     = is_div | is_rem;
   assign supported = is_dr | op == OP_MUL | op == OP_MULH;
   assign special   = ~supported | (is_dr & (rs2_val == '0 | (rs1_val == MIN_INT & rs2_val == '1)));
   assign special_res = ~supported ? '0 : rs2_val == '0 ? (is_div ? '1 : rs1_val) : (is_div ? MIN_INT : '0);
   assign abs1 = rs1_val[XLEN-1] ? -rs1_val : rs1_val;
   assign abs2 = rs2_val[XLEN-1] ? -rs2_val : rs2_val;
   // Product/division share prod_q: high half is accumulator/remainder, low half multiplier/quotient.
   assign add_w  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, m_q} : '0);
   assign rem_w  = prod_q[2*XLEN-1:XLEN-1];
   assign diff_w = rem_w - {1'b0, m_q};
   assign step = ~op_q[2] ? {add_w, prod_q[XLEN-1:1]} :
                 diff_w[XLEN] ? {rem_w[XLEN-1:0], prod_q[XLEN-2:0], 1'b0} :
                                {diff_w[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
   assign sprod = (s1_q ^ s2_q) ? -prod_q : prod_q;
   assign quo   = prod_q[XLEN-1:0];
   assign rem   = prod_q[2*XLEN-1:XLEN];
   assign fix_res = op_q == OP_MUL  ? sprod[XLEN-1:0] :
                    op_q == OP_MULH ? sprod[2*XLEN-1:XLEN] :
                    op_q == OP_DIV  ? ((s1_q ^ s2_q) ? -quo : quo) :
                                      (s1_q ? -rem : rem);
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      m_d      = m_q;
      prod_d   = prod_q;
      tag_d    = tag_q;
      rd_d     = rd_q;
      result_d = result_q;
      valid_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start & ~flush) begin
            op_d   = op;
            tag_d  = rd_in;
            s1_d   = rs1_val[XLEN-1];
            s2_d   = rs2_val[XLEN-1];
            cnt_d  = '0;
            m_d    = is_dr ? abs2 : abs1;
            prod_d = {{XLEN{1'b0}}, is_dr ? abs1 : abs2};
            state_d = special ? DONE : CALC;
            valid_d = special;
            result_d = special ? special_res : result_q;
            rd_d     = special ? rd_in : rd_q;
         end
      end else if (flush) begin
         state_d = IDLE;
      end else if (state_q == CALC) begin
         prod_d  = step;
         cnt_d   = cnt_q + ONE;
         state_d = cnt_q == LAST ? FIX : CALC;
      end else if (state_q == FIX) begin
         result_d = fix_res;
         rd_d     = tag_q;
         valid_d  = 1'b1;
         state_d  = DONE;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         m_q      <= '0;
         prod_q   <= '0;
         tag_q    <= '0;
         rd_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         m_q      <= m_d;
         prod_q   <= prod_d;
         tag_q    <= tag_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= state_d != IDLE;
      end
   end
   assign stall_req    = state_q == CALC | state_q == FIX | (state_q == IDLE & start & ~flush & ~special);
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result       = result_q;
   assign rd_out       = rd_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus flush and async-reset sequences.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        reset, start, flush, stall_req, busy, result_valid;
   logic [3:0]  op;
   logic [31:0] rs1_val, rs2_val, result;
   logic [4:0]  rd_in, rd_out;
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic        sp;
      logic [31:0] exp;
   } vec_t;
   localparam int NV = 16;
   vec_t vecs[NV];
   mul_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rd_in(rd_in), .flush(flush), .stall_req(stall_req), .busy(busy),
      .result_valid(result_valid), .result(result), .rd_out(rd_out)
   );
   always #5 clk = ~clk;
   always @(negedge clk)
      if (!reset && busy && start) begin
         errors++;
         $display("FAIL start_while_busy: start=1 while busy=1");
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic sp, input logic [31:0] exp);
      int n, stalls;
      @(negedge clk);
      op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
      #1 chk("stall_at_start", {31'b0, stall_req}, {31'b0, ~sp});
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      stalls = 0;
      if (!sp) chk("busy_in_calc", {31'b0, busy}, 32'd1);
      while (!result_valid && n < 40) begin
         if (stall_req) stalls++;
         @(posedge clk);
         #1 n++;
      end
      chk("latency", n, sp ? 0 : 33);
      chk("stall_cycles", stalls, sp ? 0 : 33);
      chk("result", result, exp);
      chk("rd_out", {27'b0, rd_out}, {27'b0, rd});
      chk("stall_in_done", {31'b0, stall_req}, 32'd0);
      @(posedge clk);
      #1 chk("valid_one_cycle", {31'b0, result_valid}, 32'd0);
      chk("busy_after", {31'b0, busy}, 32'd0);
      chk("result_held", result, exp);
   endtask
   initial begin
      vecs[0]  = '{4'b0000, 32'd7,        32'hFFFFFFFD, 5'd5,  1'b0, 32'hFFFFFFEB};
      vecs[1]  = '{4'b0001, 32'h80000000, 32'h80000000, 5'd6,  1'b0, 32'h40000000};
      vecs[2]  = '{4'b0001, 32'hFFFFFFFF, 32'd2,        5'd7,  1'b0, 32'hFFFFFFFF};
      vecs[3]  = '{4'b0100, 32'hFFFFFFF9, 32'd2,        5'd8,  1'b0, 32'hFFFFFFFD};
      vecs[4]  = '{4'b0110, 32'hFFFFFFF9, 32'd2,        5'd9,  1'b0, 32'hFFFFFFFF};
      vecs[5]  = '{4'b0100, 32'd100,      32'd7,        5'd10, 1'b0, 32'd14};
      vecs[6]  = '{4'b0110, 32'd100,      32'd7,        5'd11, 1'b0, 32'd2};
      vecs[7]  = '{4'b0100, 32'd5,        32'd0,        5'd12, 1'b1, 32'hFFFFFFFF};
      vecs[8]  = '{4'b0110, 32'd5,        32'd0,        5'd13, 1'b1, 32'd5};
      vecs[9]  = '{4'b0100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 1'b1, 32'h80000000};
      vecs[10] = '{4'b0110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1'b1, 32'd0};
      vecs[11] = '{4'b1111, 32'd3,        32'd4,        5'd16, 1'b1, 32'd0};
      vecs[12] = '{4'b0110, 32'hFFFFFF9C, 32'd7,        5'd17, 1'b0, 32'hFFFFFFFE};
      vecs[13] = '{4'b0100, 32'd100,      32'hFFFFFFF9, 5'd18, 1'b0, 32'hFFFFFFF2};
      vecs[14] = '{4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 1'b0, 32'd1};
      vecs[15] = '{4'b0001, 32'd7,        32'hFFFFFFFD, 5'd20, 1'b0, 32'hFFFFFFFF};
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
      #12;
      chk("reset_result", result, 32'd0);
      chk("reset_rd_out", {27'b0, rd_out}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_valid", {31'b0, result_valid}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < NV; i++) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].sp, vecs[i].exp);
      // Flush at iteration 10: the previous result (vector 15) must survive.
      @(negedge clk);
      op = 4'b0000; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd21; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_valid", {31'b0, result_valid}, 32'd0);
      chk("flush_result", result, 32'hFFFFFFFF);
      chk("flush_rd_out", {27'b0, rd_out}, 32'd20);
      repeat (40) begin
         @(posedge clk);
         #1 if (result_valid) chk("flush_no_valid", 32'd1, 32'd0);
      end
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 4'b0000; rs1_val = 32'd3; rs2_val = 32'd4;
      #1 chk("flush_start_stall", {31'b0, stall_req}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      chk("flush_start_ignored", {31'b0, busy}, 32'd0);
      run(4'b0000, 32'd3, 32'd4, 5'd21, 1'b0, 32'd12);
      @(negedge clk);
      op = 4'b0100; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #3 reset = 1'b1;
      #1 chk("areset_result", result, 32'd0);
      chk("areset_rd_out", {27'b0, rd_out}, 32'd0);
      chk("areset_busy", {31'b0, busy}, 32'd0);
      chk("areset_stall", {31'b0, stall_req}, 32'd0);
      chk("areset_valid", {31'b0, result_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run(4'b0100, 32'd9, 32'd3, 5'd4, 1'b0, 32'd3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
